// File: rtl/muxpipe_pkg.sv
// Shared definitions for the N-input pipelined selector.
//   state_t : occupancy of the output stage (EMPTY / ONE / TWO words held)
//   clog2   : index width for a channel count, never less than 1
package muxpipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant among requesting channels.
//   req     : per-channel request
//   ptr     : highest-priority channel index for this cycle
//   gnt_idx : first requesting channel at or after ptr (wrapping N-1 -> 0)
//   gnt_vld : at least one channel is requesting
module rr_arbiter
  import muxpipe_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [N-1:0]           at_or_after;
  logic [N-1:0]           upper_req;
  logic [N-1:0]           pick;
  logic [N-1:0]           lowest_oh;
  logic [SELW-1:0][N-1:0] enc_cols;

  genvar gi, gb;

  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign at_or_after[gi] = (SELW'(gi) >= ptr);
    end
  endgenerate

  // Requests at or above the pointer win; if there are none, wrap around
  // and take the lowest requester overall.
  assign upper_req = req & at_or_after;
  assign pick      = (|upper_req) ? upper_req : req;

  // Isolate the lowest set bit (two's complement trick).
  assign lowest_oh = pick & ((~pick) + N'(1));

  // One-hot to binary: index bit gb is the OR of channels whose index has bit gb set.
  generate
    for (gb = 0; gb < SELW; gb++) begin : g_enc
      for (gi = 0; gi < N; gi++) begin : g_ch
        if (((gi >> gb) & 1) == 1) begin : g_one
          assign enc_cols[gb][gi] = lowest_oh[gi];
        end else begin : g_zero
          assign enc_cols[gb][gi] = 1'b0;
        end
      end
      assign gnt_idx[gb] = |enc_cols[gb];
    end
  endgenerate

  assign gnt_vld = |req;

endmodule

// File: rtl/muxn_pipe.sv
// N-input, WIDTH-bit selector with a registered output and a 2-entry skid
// buffer behind a valid/ready handshake.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_data/in_valid    : N channels, channel i at in_data[i*WIDTH +: WIDTH]
//   in_ready            : one-hot (or zero) ready towards the granted channel
//   sel                 : channel index in MODE 0 (ignored in MODE 1)
//   flush               : synchronous drop of all buffered words
//   out_data/out_src    : registered word and the channel it came from
//   out_valid/out_ready : downstream handshake
module muxn_pipe
  import muxpipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = 0,
  localparam int SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0]       m_data_reg, m_data_next;
  logic [SELW-1:0]        m_src_reg, m_src_next;
  logic [WIDTH-1:0]       s_data_reg, s_data_next;
  logic [SELW-1:0]        s_src_reg, s_src_next;
  logic [SELW-1:0]        ptr_reg, ptr_next;

  logic [SELW-1:0]        gnt_idx;
  logic                   gnt_vld;
  logic [N-1:0]           gnt_oh;
  logic [WIDTH-1:0]       gnt_data;
  logic [WIDTH-1:0][N-1:0] bit_cols;
  logic                   can_take;
  logic                   accept;
  logic                   pop;

  genvar gi, gb;

  // ---------------- grant ----------------
  generate
    if (MODE == 1) begin : g_rr
      rr_arbiter #(
        .N    (N),
        .SELW (SELW)
      ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_reg),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
      );
    end else begin : g_ext
      // Compare against every legal index so an out-of-range sel simply
      // matches nothing and never indexes past the channel vector.
      logic [N-1:0] sel_hit;
      for (gi = 0; gi < N; gi++) begin : g_hit
        assign sel_hit[gi] = in_valid[gi] && (sel == SELW'(gi));
      end
      assign gnt_idx = sel;
      assign gnt_vld = |sel_hit;
    end
  endgenerate

  generate
    for (gi = 0; gi < N; gi++) begin : g_oh
      assign gnt_oh[gi] = gnt_vld && (gnt_idx == SELW'(gi));
    end
  endgenerate

  // Ready is also held low while reset is asserted so no handshake can
  // complete against a stage that is being cleared.
  assign can_take = rst_n && (state_reg != TWO) && !flush;
  assign in_ready = can_take ? gnt_oh : '0;
  assign accept   = |(in_valid & in_ready);
  assign pop      = out_valid && out_ready;

  // AND-OR data mux: only the granted channel's bits reach gnt_data.
  generate
    for (gb = 0; gb < WIDTH; gb++) begin : g_bit
      for (gi = 0; gi < N; gi++) begin : g_ch
        assign bit_cols[gb][gi] = gnt_oh[gi] & in_data[gi*WIDTH + gb];
      end
      assign gnt_data[gb] = |bit_cols[gb];
    end
  endgenerate

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= EMPTY;
      m_data_reg <= '0;
      m_src_reg  <= '0;
      s_data_reg <= '0;
      s_src_reg  <= '0;
      ptr_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      m_data_reg <= m_data_next;
      m_src_reg  <= m_src_next;
      s_data_reg <= s_data_next;
      s_src_reg  <= s_src_next;
      ptr_reg    <= ptr_next;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_next  = state_reg;
    m_data_next = m_data_reg;
    m_src_next  = m_src_reg;
    s_data_next = s_data_reg;
    s_src_next  = s_src_reg;
    ptr_next    = ptr_reg;

    if (flush) begin
      // Main register keeps its data; only occupancy is dropped.
      state_next  = EMPTY;
      s_data_next = '0;
      s_src_next  = '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            m_data_next = gnt_data;
            m_src_next  = gnt_idx;
            state_next  = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_data_next = gnt_data;
            m_src_next  = gnt_idx;
          end else if (accept) begin
            s_data_next = gnt_data;
            s_src_next  = gnt_idx;
            state_next  = TWO;
          end else if (pop) begin
            state_next  = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            m_data_next = s_data_reg;
            m_src_next  = s_src_reg;
            s_data_next = '0;
            s_src_next  = '0;
            state_next  = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase

      if (MODE == 1 && accept) begin
        ptr_next = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
      end
    end
  end

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = m_data_reg;
  assign out_src   = m_src_reg;

endmodule
